// File: rtl/multicycle_unit_sequencer.sv
// Purpose: issues one op at a time to NUNITS iterative units and returns each result as a one-cycle strobe.
// Latency: a request in cycle 0 to a unit that finishes k edges after its start gives resp_valid in cycle 2+k.
// An illegal unit gives resp_valid in cycle 1. Backpressure: stall holds the pipeline from acceptance
// through WAIT and drops in DONE. Requests outside IDLE are ignored, and a held request is taken in the next IDLE.
module multicycle_unit_sequencer #(
  parameter int NUNITS  = 4,
  parameter int UW      = 2,
  parameter int TIMEOUT = 64
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  input  logic [UW-1:0]       req_unit,
  input  logic [31:0]         req_a,
  input  logic [31:0]         req_b,
  output logic                req_ready,
  output logic                stall,
  output logic [NUNITS-1:0]   unit_start,
  output logic [31:0]         unit_a,
  output logic [31:0]         unit_b,
  input  logic [NUNITS-1:0]   unit_busy,
  input  logic [32*NUNITS-1:0] unit_result,
  output logic                resp_valid,
  output logic [31:0]         resp_data,
  output logic                resp_error
);

  // Sequencer states
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] LAUNCH = 2'd1;
  localparam logic [1:0] WAIT   = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  // Watchdog counts WAIT cycles 0..TIMEOUT-1
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

  // One past the highest legal unit index, widened so NUNITS == 2**UW still fits
  localparam logic [UW:0] UNIT_LIMIT = (UW+1)'(NUNITS);

  logic [1:0]        state;
  logic [1:0]        next_state;
  logic [UW-1:0]     sel;
  logic [TW-1:0]     timer;
  logic              req_legal;
  logic              accept;
  logic              timer_expired;
  logic              enter_done;
  logic              sel_busy;
  logic [31:0]       sel_result;
  logic [NUNITS-1:0] launch_onehot;

  assign req_legal     = ({1'b0, req_unit} < UNIT_LIMIT);
  assign accept        = (state == IDLE) && req_valid;
  assign timer_expired = (timer == TIMER_LAST);
  assign enter_done    = (state != DONE) && (next_state == DONE);

  assign req_ready = (state == IDLE);
  // Combinational so the stalled pipeline freezes in the same cycle it presents a request
  assign stall     = accept || (state == LAUNCH) || (state == WAIT);

  // Pick out the selected unit's busy and result; other units are ignored
  always_comb begin
    sel_busy   = 1'b0;
    sel_result = '0;
    for (int i = 0; i < NUNITS; i++) begin
      if (sel == UW'(i)) begin
        sel_busy   = unit_busy[i];
        sel_result = unit_result[32*i +: 32];
      end
    end
  end

  // Decode the incoming unit index into the start vector that is loaded on acceptance
  always_comb begin
    launch_onehot = '0;
    for (int i = 0; i < NUNITS; i++) begin
      launch_onehot[i] = (req_unit == UW'(i));
    end
  end

  // Next-state logic; illegal selects skip the unit and go straight to DONE
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (req_valid) begin
          next_state = req_legal ? LAUNCH : DONE;
        end
      end
      LAUNCH: next_state = WAIT;
      WAIT: begin
        if (!sel_busy || timer_expired) begin
          next_state = DONE;
        end
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // State register; reset aborts any op in flight without a response
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Capture the target and operands on acceptance; they stay put until the next accepted op
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sel    <= '0;
      unit_a <= '0;
      unit_b <= '0;
    end else if (accept && req_legal) begin
      sel    <= req_unit;
      unit_a <= req_a;
      unit_b <= req_b;
    end
  end

  // Start pulse is registered, so it is high only during the single LAUNCH cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      unit_start <= '0;
    end else if (accept && req_legal) begin
      unit_start <= launch_onehot;
    end else begin
      unit_start <= '0;
    end
  end

  // Watchdog: cleared in LAUNCH and advanced each WAIT cycle in which the unit is still busy
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timer <= '0;
    end else if (state == LAUNCH) begin
      timer <= '0;
    end else if ((state == WAIT) && sel_busy && !timer_expired) begin
      timer <= timer + 1'b1;
    end
  end

  // Response: strobe on entry to DONE. Data and error hold until the next completion.
  // A finished unit beats the watchdog in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      resp_valid <= 1'b0;
      resp_data  <= '0;
      resp_error <= 1'b0;
    end else begin
      resp_valid <= enter_done;
      if (accept && !req_legal) begin
        resp_data  <= '0;
        resp_error <= 1'b1;
      end else if ((state == WAIT) && !sel_busy) begin
        resp_data  <= sel_result;
        resp_error <= 1'b0;
      end else if ((state == WAIT) && timer_expired) begin
        resp_data  <= '0;
        resp_error <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_multicycle_unit_sequencer.sv
// Directed bench for multicycle_unit_sequencer with three attached units.
// Unit 0 is an iterative CLZ, unit 1 is stuck busy and unit 2 is a slow adder.
// Unit index 3 is illegal.
module tb_multicycle_unit_sequencer;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic [1:0]  req_unit;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        req_ready;
  logic        stall;
  logic [2:0]  unit_start;
  logic [31:0] unit_a;
  logic [31:0] unit_b;
  logic [2:0]  unit_busy;
  logic [95:0] unit_result;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        resp_error;

  int nvec = 0;
  int nbad = 0;

  multicycle_unit_sequencer #(.NUNITS(3), .UW(2), .TIMEOUT(64)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_unit(req_unit), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .stall(stall),
    .unit_start(unit_start), .unit_a(unit_a), .unit_b(unit_b),
    .unit_busy(unit_busy), .unit_result(unit_result),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_error(resp_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- unit models ----------------
  function automatic logic [31:0] clz32(input logic [31:0] v);
    logic [31:0] n;
    logic found;
    n = 0;
    found = 1'b0;
    for (int i = 31; i >= 0; i--) begin
      if (v[i]) found = 1'b1;
      else if (!found) n = n + 1;
    end
    return n;
  endfunction

  logic [31:0] clz_n;
  logic        busy0;
  logic [5:0]  rem0;
  logic [31:0] res0;
  logic        busy2;
  logic [1:0]  cnt2;
  logic [31:0] res2;

  assign clz_n = clz32(unit_a);

  // CLZ unit: done n+1 edges after start, counting the start edge
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      busy0 <= 1'b0; rem0 <= '0; res0 <= '0;
    end else if (unit_start[0]) begin
      res0  <= clz_n;
      rem0  <= clz_n[5:0];
      busy0 <= (clz_n != 0);
    end else if (busy0) begin
      rem0  <= rem0 - 6'd1;
      busy0 <= (rem0 != 6'd1);
    end
  end

  // Adder unit: busy for three cycles after start
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      busy2 <= 1'b0; cnt2 <= '0; res2 <= '0;
    end else if (unit_start[2]) begin
      res2  <= unit_a + unit_b;
      cnt2  <= 2'd3;
      busy2 <= 1'b1;
    end else if (busy2) begin
      cnt2  <= cnt2 - 2'd1;
      busy2 <= (cnt2 != 2'd1);
    end
  end

  assign unit_busy   = {busy2, 1'b1, busy0};
  assign unit_result = {res2, 32'hDEAD_BEEF, res0};

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nbad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Issue one request in cycle 0 (caller is just after a posedge in IDLE) and follow it to DONE
  task automatic run_op(input string tag, input logic [1:0] u, input logic [31:0] a, input logic [31:0] b,
                        input int exp_lat, input logic [31:0] exp_data, input logic exp_err,
                        input logic [2:0] exp_start, input int exp_starts);
    int seen, lat, starts, stall_cnt;
    logic [2:0] startv;
    logic [31:0] d, ua, ub;
    logic e, st_done;
    seen = 0; lat = -1; starts = 0; stall_cnt = 0; startv = '0;
    d = '0; e = 1'b0; ua = '0; ub = '0; st_done = 1'b1;
    req_valid = 1'b1; req_unit = u; req_a = a; req_b = b;
    for (int c = 0; c < 200 && seen == 0; c++) begin
      @(negedge clk);
      if (unit_start != 3'b000) begin
        starts++;
        startv = unit_start;
      end
      if (resp_valid) begin
        seen = 1; lat = c; d = resp_data; e = resp_error;
        ua = unit_a; ub = unit_b; st_done = stall;
      end else if (stall) begin
        stall_cnt++;
      end
      @(posedge clk); #1;
      if (c == 0) req_valid = 1'b0;
    end
    chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_data"}, d, exp_data);
    chk({tag, "_error"}, {31'd0, e}, {31'd0, exp_err});
    chk({tag, "_start_vec"}, {29'd0, startv}, {29'd0, exp_start});
    chk({tag, "_start_cnt"}, 32'(starts), 32'(exp_starts));
    chk({tag, "_stall_cycles"}, 32'(stall_cnt), 32'(exp_lat));
    chk({tag, "_stall_in_done"}, {31'd0, st_done}, 32'd0);
    if (exp_starts != 0) begin
      chk({tag, "_unit_a_held"}, ua, a);
      chk({tag, "_unit_b_held"}, ub, b);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int resp_cnt, starts;
    int first_resp, second_resp;
    logic [31:0] d1, d2;

    reset = 1'b1; req_valid = 1'b0; req_unit = '0; req_a = '0; req_b = '0;
    #12;
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_unit_start", {29'd0, unit_start}, 32'd0);
    chk("rst_unit_a", unit_a, 32'd0);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_resp_data", resp_data, 32'd0);
    chk("rst_resp_error", {31'd0, resp_error}, 32'd0);
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;

    // CLZ with no leading zeros, CLZ of zero, CLZ of 0xff
    run_op("clz_msb", 2'd0, 32'h8000_0000, 32'h0, 3, 32'd0, 1'b0, 3'b001, 1);
    run_op("clz_zero", 2'd0, 32'h0, 32'h5, 35, 32'd32, 1'b0, 3'b001, 1);
    run_op("clz_ff", 2'd0, 32'h0000_00FF, 32'h0, 27, 32'd24, 1'b0, 3'b001, 1);

    // Request held high across DONE: second op accepted in cycle 19, launched in cycle 20
    req_valid = 1'b1; req_unit = 2'd0; req_a = 32'h0001_0000; req_b = 32'h0;
    resp_cnt = 0; starts = 0; first_resp = -1; second_resp = -1; d1 = '0; d2 = '0;
    for (int c = 0; c < 45; c++) begin
      @(negedge clk);
      if (unit_start[0]) starts++;
      if (c == 18) chk("b2b_stall_in_done", {31'd0, stall}, 32'd0);
      if (c == 19) begin
        chk("b2b_ready_c19", {31'd0, req_ready}, 32'd1);
        chk("b2b_stall_c19", {31'd0, stall}, 32'd1);
      end
      if (c == 20) chk("b2b_start_c20", {29'd0, unit_start}, 32'd1);
      if (resp_valid) begin
        resp_cnt++;
        if (resp_cnt == 1) begin first_resp = c; d1 = resp_data; end
        else begin second_resp = c; d2 = resp_data; end
      end
      @(posedge clk); #1;
      if (c == 19) req_valid = 1'b0;
    end
    chk("b2b_first_cycle", 32'(first_resp), 32'd18);
    chk("b2b_first_data", d1, 32'd15);
    chk("b2b_second_cycle", 32'(second_resp), 32'd37);
    chk("b2b_second_data", d2, 32'd15);
    chk("b2b_start_cnt", 32'(starts), 32'd2);
    chk("b2b_resp_cnt", 32'(resp_cnt), 32'd2);

    // Illegal index, stuck-busy timeout, then the adder unit
    run_op("illegal", 2'd3, 32'h1111_1111, 32'h2222_2222, 1, 32'd0, 1'b1, 3'b000, 0);
    run_op("timeout", 2'd1, 32'h0000_0001, 32'h0, 66, 32'd0, 1'b1, 3'b010, 1);
    run_op("adder", 2'd2, 32'd100, 32'd23, 6, 32'd123, 1'b0, 3'b100, 1);

    // Reset in cycle 10 of a CLZ of zero
    req_valid = 1'b1; req_unit = 2'd0; req_a = 32'h0; req_b = 32'h0000_1234;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (c == 0) req_valid = 1'b0;
    end
    chk("mid_stall_before_rst", {31'd0, stall}, 32'd1);
    #3 reset = 1'b1;
    #1;
    chk("mid_rst_ready", {31'd0, req_ready}, 32'd1);
    chk("mid_rst_stall", {31'd0, stall}, 32'd0);
    chk("mid_rst_unit_b", unit_b, 32'd0);
    chk("mid_rst_resp_data", resp_data, 32'd0);
    chk("mid_rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("mid_rst_unit_start", {29'd0, unit_start}, 32'd0);
    @(negedge clk); reset = 1'b0;
    resp_cnt = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (resp_valid) resp_cnt++;
    end
    chk("mid_rst_no_resp", 32'(resp_cnt), 32'd0);
    @(posedge clk); #1;
    run_op("after_rst", 2'd0, 32'h0000_0100, 32'h0, 26, 32'd23, 1'b0, 3'b001, 1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
